// File: rtl/vga_scanout_160x120.sv
// 640x480@60 scanout for a 160x120 3-bit image RAM shown as 4x4 blocks.
// Counter decode, RAM read and output registers form a fixed 2-clk pipeline.
module vga_scanout_160x120 #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] rd_x,
    output logic [6:0] rd_y,
    input  logic [2:0] rd_data,
    output logic [2:0] vga_rgb,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] H_HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;

    logic active_p0, hs_p0, vs_p0, fs_p0;
    logic active_p1_q, hs_p1_q, vs_p1_q, fs_p1_q;

    logic [2:0] vga_rgb_q;
    logic       vga_hs_q, vga_vs_q, vga_blank_n_q, frame_start_q;

    always_comb begin
        hcnt_d = hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Stage 0: decode counters; blanking addresses pinned to 0 keep the RAM in range
    assign active_p0 = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    assign hs_p0     = !((hcnt_q >= H_HS_BEG) && (hcnt_q < H_HS_END));
    assign vs_p0     = !((vcnt_q >= V_VS_BEG) && (vcnt_q < V_VS_END));
    assign fs_p0     = (hcnt_q == '0) && (vcnt_q == '0);

    assign rd_x = active_p0 ? 8'(hcnt_q >> SCALE_SHIFT) : 8'd0;
    assign rd_y = active_p0 ? 7'(vcnt_q >> SCALE_SHIFT) : 7'd0;

    // Stage 1: control delayed to match the RAM's one-cycle read
    always_ff @(posedge clk) begin
        if (reset) begin
            active_p1_q <= 1'b0;
            hs_p1_q     <= 1'b1;
            vs_p1_q     <= 1'b1;
            fs_p1_q     <= 1'b0;
        end else begin
            active_p1_q <= active_p0;
            hs_p1_q     <= hs_p0;
            vs_p1_q     <= vs_p0;
            fs_p1_q     <= fs_p0;
        end
    end

    // Stage 2: output registers, colour forced black outside the visible area
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_rgb_q     <= 3'b000;
            vga_hs_q      <= 1'b1;
            vga_vs_q      <= 1'b1;
            vga_blank_n_q <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            vga_rgb_q     <= active_p1_q ? rd_data : 3'b000;
            vga_hs_q      <= hs_p1_q;
            vga_vs_q      <= vs_p1_q;
            vga_blank_n_q <= active_p1_q;
            frame_start_q <= fs_p1_q;
        end
    end

    assign vga_rgb     = vga_rgb_q;
    assign vga_hs      = vga_hs_q;
    assign vga_vs      = vga_vs_q;
    assign vga_blank_n = vga_blank_n_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout_160x120.sv
// Bench for vga_scanout_160x120 with a shortened vertical frame; a
// screen-position model predicts every output from the timing rules.
module tb_vga_scanout_160x120;

    localparam int HA = 640, HFP = 16, HS = 96, HBP = 48;
    localparam int VA = 8, VFP = 2, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rd_x;
    logic [6:0] rd_y;
    logic [2:0] rd_data;
    logic [2:0] vga_rgb;
    logic       vga_hs, vga_vs, vga_blank_n, frame_start;

    vga_scanout_160x120 #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SCALE_SHIFT(2)
    ) dut (
        .clk(clk), .reset(reset), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
        .vga_rgb(vga_rgb), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int k = 0;
    int mode = 0;
    bit mon_en = 1'b0;
    logic [2:0] ram_mem [0:119][0:159];

    typedef struct packed {
        logic [2:0] rgb;
        logic       bn;
        logic       hs;
        logic       vs;
        logic       fs;
    } out_t;

    typedef struct {
        int         sx;
        int         sy;
        logic [2:0] rgb;
        logic       bn;
        logic       hs;
        logic       vs;
        logic       fs;
    } vec_t;

    vec_t tbl [16];

    // Image RAM contents: 0 = (x+y)%8 pattern, 1 = all white, 2 = random
    function automatic logic [2:0] ram_val(int x, int y);
        if (x > 159 || y > 119) return 3'd0;
        case (mode)
            0:       return 3'((x + y) % 8);
            1:       return 3'b111;
            default: return ram_mem[y][x];
        endcase
    endfunction

    always @(posedge clk) begin
        rd_data <= ram_val(int'(rd_x), int'(rd_y));
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    function automatic out_t model(int p);
        out_t o;
        int sx, sy;
        sx = p % HT;
        sy = p / HT;
        o.bn  = (sx < HA) && (sy < VA);
        o.hs  = !(sx >= HA + HFP && sx < HA + HFP + HS);
        o.vs  = !(sy >= VA + VFP && sy < VA + VFP + VS);
        o.fs  = (p == 0);
        o.rgb = o.bn ? ram_val(sx / 4, sy / 4) : 3'd0;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_pos(input int p);
        int n;
        n = 0;
        while (!(k >= 2 && (k - 2) % FRAME == p)) begin
            @(negedge clk);
            n++;
            if (n > FRAME + 100) begin
                total++;
                bad++;
                $display("FAIL wait_pos: position %0d not reached within %0d clks", p, n);
                return;
            end
        end
    endtask

    // Continuous comparison of every output and of the read address
    always @(negedge clk) begin
        out_t e;
        int q, qx, qy;
        if (mon_en && !reset && k >= 2) begin
            e = model((k - 2) % FRAME);
            check("mon_rgb", vga_rgb, e.rgb);
            check("mon_blank_n", vga_blank_n, e.bn);
            check("mon_hs", vga_hs, e.hs);
            check("mon_vs", vga_vs, e.vs);
            check("mon_fs", frame_start, e.fs);
            q  = k % FRAME;
            qx = q % HT;
            qy = q / HT;
            check("mon_rd_x", rd_x, (qx < HA && qy < VA) ? qx / 4 : 0);
            check("mon_rd_y", rd_y, (qx < HA && qy < VA) ? qy / 4 : 0);
            check("mon_rd_bounds", (rd_x <= 8'd159) && (rd_y <= 7'd119), 1);
        end
    end

    initial begin
        int act_cnt, vs_cnt, fs_cnt, vs_first, l_bn, l_hs, hs_first, bn_fall, hs_falls;
        int rp, n;
        logic prev_hs;

        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                ram_mem[y][x] = 3'($urandom);

        tbl[0]  = '{0,   0,  3'd0, 1, 1, 1, 1};
        tbl[1]  = '{1,   0,  3'd0, 1, 1, 1, 0};
        tbl[2]  = '{3,   0,  3'd0, 1, 1, 1, 0};
        tbl[3]  = '{4,   0,  3'd1, 1, 1, 1, 0};
        tbl[4]  = '{639, 0,  3'd7, 1, 1, 1, 0};
        tbl[5]  = '{640, 0,  3'd0, 0, 1, 1, 0};
        tbl[6]  = '{655, 0,  3'd0, 0, 1, 1, 0};
        tbl[7]  = '{656, 0,  3'd0, 0, 0, 1, 0};
        tbl[8]  = '{751, 0,  3'd0, 0, 0, 1, 0};
        tbl[9]  = '{752, 0,  3'd0, 0, 1, 1, 0};
        tbl[10] = '{0,   4,  3'd1, 1, 1, 1, 0};
        tbl[11] = '{5,   4,  3'd2, 1, 1, 1, 0};
        tbl[12] = '{0,   8,  3'd0, 0, 1, 1, 0};
        tbl[13] = '{0,   10, 3'd0, 0, 1, 0, 0};
        tbl[14] = '{799, 11, 3'd0, 0, 1, 0, 0};
        tbl[15] = '{0,   12, 3'd0, 0, 1, 1, 0};

        mode  = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rgb", vga_rgb, 0);
        check("rst_hs", vga_hs, 1);
        check("rst_vs", vga_vs, 1);
        check("rst_blank_n", vga_blank_n, 0);
        check("rst_fs", frame_start, 0);
        check("rst_rd_x", rd_x, 0);
        check("rst_rd_y", rd_y, 0);
        reset  = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 16; i++) begin
            wait_pos(tbl[i].sy * HT + tbl[i].sx);
            check($sformatf("tbl%0d_rgb", i), vga_rgb, tbl[i].rgb);
            check($sformatf("tbl%0d_blank_n", i), vga_blank_n, tbl[i].bn);
            check($sformatf("tbl%0d_hs", i), vga_hs, tbl[i].hs);
            check($sformatf("tbl%0d_vs", i), vga_vs, tbl[i].vs);
            check($sformatf("tbl%0d_fs", i), frame_start, tbl[i].fs);
        end

        // Random image from here on; switched while the whole pipeline is blanked
        mode = 2;
        wait_pos(0);
        act_cnt = 0; vs_cnt = 0; fs_cnt = 0; vs_first = -1;
        l_bn = 0; l_hs = 0; hs_first = -1; bn_fall = -1; hs_falls = 0;
        prev_hs = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            if (vga_blank_n) act_cnt++;
            if (!vga_vs) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = i;
            end
            if (frame_start) fs_cnt++;
            if (prev_hs && !vga_hs) hs_falls++;
            prev_hs = vga_hs;
            if (i < HT) begin
                if (vga_blank_n) l_bn++;
                if (!vga_blank_n && bn_fall < 0) bn_fall = i;
                if (!vga_hs) begin
                    l_hs++;
                    if (hs_first < 0) hs_first = i;
                end
            end
            @(negedge clk);
        end
        check("line_blank_n_high", l_bn, HA);
        check("line_hs_low", l_hs, HS);
        check("line_hs_after_blank", hs_first - bn_fall, HFP);
        check("frame_hs_pulses", hs_falls, VT);
        check("frame_active_clks", act_cnt, HA * VA);
        check("frame_vs_low_clks", vs_cnt, VS * HT);
        check("frame_vs_start", vs_first, (VA + VFP) * HT);
        check("frame_fs_count", fs_cnt, 1);

        // All-white image exposes any colour leaking into blanking
        wait_pos(VA * HT + 50);
        mode = 1;
        rp = $urandom_range(VA - 1, 2) * HT + $urandom_range(HA - 1, 0);
        wait_pos(rp);

        reset = 1'b1;
        @(negedge clk);
        check("midrst_rgb", vga_rgb, 0);
        check("midrst_hs", vga_hs, 1);
        check("midrst_vs", vga_vs, 1);
        check("midrst_blank_n", vga_blank_n, 0);
        check("midrst_fs", frame_start, 0);
        check("midrst_rd_x", rd_x, 0);
        check("midrst_rd_y", rd_y, 0);
        repeat (4) @(negedge clk);
        check("midrst_hold_blank_n", vga_blank_n, 0);
        check("midrst_hold_hs", vga_hs, 1);
        reset = 1'b0;
        @(negedge clk);
        check("post1_fs", frame_start, 0);
        check("post1_blank_n", vga_blank_n, 0);
        check("post1_hs", vga_hs, 1);
        check("post1_vs", vga_vs, 1);
        check("post1_rgb", vga_rgb, 0);
        @(negedge clk);
        check("post2_fs", frame_start, 1);
        check("post2_blank_n", vga_blank_n, 1);
        check("post2_rgb", vga_rgb, 3'b111);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n <= FRAME + 10);
        check("fs_period", n, FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_scanout_160x120.md
Name: vga_scanout_160x120

Overview:
- Display-side reader for the 160x120, 3-bit-RGB image RAM.
- Generates 640x480@60 VGA timing from a pixel-rate clock and computes the RAM read coordinates (x,y) for each 4x4 screen block.
- Captures the RAM's one-cycle synchronous read data and drives RGB, sync and blank outputs, all aligned to each other.
- Sits between the image RAM read port and the board VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SCALE_SHIFT, 2, log2 of screen pixels per image pixel per axis (4x4 block)

Ports:
clk  input  1  pixel clock (25 MHz nominal)
reset  input  1  synchronous, active-high reset
rd_x  output  8  image RAM column, 0..159
rd_y  output  7  image RAM row, 0..119
rd_data  input  3  image RAM dout, valid one clk after rd_x/rd_y
vga_rgb  output  3  pixel colour {R,G,B}
vga_hs  output  1  horizontal sync, active low
vga_vs  output  1  vertical sync, active low
vga_blank_n  output  1  high while visible pixel is on vga_rgb
frame_start  output  1  one-cycle pulse coincident with output pixel (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counters:
  - hcnt and vcnt are 10-bit registers.
  - hcnt increments every clk; at H_TOTAL-1 it wraps to 0 and vcnt advances.
  - vcnt wraps from V_TOTAL-1 to 0.
  - No free-running states beyond these counters.
- Stage 0 (counters, combinational decode):
  - active0 = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
  - hs0 = low when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vs0 = low when V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC.
  - fs0 = (hcnt==0 && vcnt==0).
  - rd_x = active0 ? hcnt>>SCALE_SHIFT : 0; rd_y = active0 ? vcnt>>SCALE_SHIFT : 0.
  - In blanking, rd_x/rd_y are forced to 0 so the RAM address never exceeds 19199.
- Stage 1: register active0, hs0, vs0, fs0 (RAM read occurs in this cycle).
- Stage 2 (output registers):
  - vga_rgb <= active1 ? rd_data : 3'b000.
  - vga_hs <= hs1; vga_vs <= vs1; vga_blank_n <= active1; frame_start <= fs1.
- Latency: all outputs lag the counter state that produced them by exactly 2 clks, so RGB, sync and blank stay mutually aligned.
- Reset, effective at the next clk edge:
  - hcnt = vcnt = 0; all stage-1/stage-2 registers cleared.
  - Outputs: vga_rgb = 0, vga_hs = 1, vga_vs = 1, vga_blank_n = 0, frame_start = 0.
  - rd_x = rd_y = 0.
- Reset mid-frame: aborts the current frame. After reset deasserts, the first frame_start appears 2 clks after the first counter state (0,0), i.e. on the 2nd rising edge with reset low.
- The block never writes the RAM and performs no handshake. It assumes a read port with fixed 1-cycle latency and no stall.
- Every image pixel is displayed as a 4x4 block. Image row y occupies screen lines 4y..4y+3.
- Frame period: H_TOTAL*V_TOTAL = 420000 clks.

Test Plan:
- Reset: assert reset 5 clks mid-line, deassert → outputs hold reset values, then frame_start pulses exactly 2 clks after counters reach (0,0); next pulse 420000 clks later.
- Horizontal timing: count clks per line → vga_blank_n high for 640 clks, vga_hs low for exactly 96 clks starting 16 clks after blank_n falls, line period 800 clks.
- Vertical timing: over one frame → blank_n active on 480 lines, vga_vs low for exactly 2 lines (1600 clks) starting 10 lines after the last active line, frame 525 lines.
- Pixel alignment: behavioral RAM model with 1-clk latency, data = (x+y)%8 → output pixel at screen (sx,sy) equals ((sx>>2)+(sy>>2))%8. Screen pixels (3,0)/(4,0) show 0/1, and (0,4) shows 1.
- Address bounds: monitor rd_x/rd_y every clk → always rd_x<=159, rd_y<=119, and both equal 0 whenever hcnt>=640 or vcnt>=480.
- Blank forcing: RAM model returns 3'b111 constantly → vga_rgb == 0 whenever vga_blank_n==0 and 3'b111 otherwise.
